stream_mux: RTL and testbench

Parametrised M-to-1 stream multiplexer with a valid/ready handshake and a registered output. It is the successor to the combinational 2:1/4:1 muxes. Channel selection is either an external select (fixed mode) or an internal round-robin arbiter. It sits between multiple producers and a single consumer on any datapath that needs flow control.

---
 rtl/stream_mux.sv | 102 ++++++++++
 tb/tb_stream_mux.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/stream_mux.sv
// M-to-1 valid/ready stream multiplexer with a registered output stage.
// The channel is chosen either by an external select (mode=0) or by a round-robin arbiter (mode=1).
module stream_mux #(
  parameter int unsigned N  = 32,
  parameter int unsigned M  = 4,
  parameter int unsigned SW = $clog2(M)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [SW-1:0]  S,
  input  logic [M*N-1:0] in_data,
  input  logic [M-1:0]   in_valid,
  output logic [M-1:0]   in_ready,
  output logic [N-1:0]   Y,
  output logic           Y_valid,
  output logic [SW-1:0]  Y_ch,
  input  logic           Y_ready
);

  logic [N-1:0]  r_y;
  logic [SW-1:0] r_y_ch;
  logic          r_y_valid;
  logic [SW-1:0] r_ptr;

  logic          w_load_en;
  logic          w_fix_vld;
  logic          w_rr_vld;
  logic [SW-1:0] w_rr_grant;
  logic          w_grant_vld;
  logic [SW-1:0] w_grant;
  logic [N-1:0]  w_grant_data;

  // The output slot can take a new beat when it is empty or being drained this cycle.
  assign w_load_en = !r_y_valid || Y_ready;

  // Fixed select: an S beyond the last channel never matches, so nothing is granted.
  always_comb begin
    w_fix_vld = 1'b0;
    for (int unsigned i = 0; i < M; i++) begin
      if (S == SW'(i)) w_fix_vld = in_valid[SW'(i)];
    end
  end

  // Round-robin: scan from ptr+1 upward, wrapping, first valid channel wins.
  always_comb begin
    int unsigned idx;
    w_rr_vld   = 1'b0;
    w_rr_grant = r_ptr;
    idx        = 0;
    for (int unsigned k = 1; k <= M; k++) begin
      idx = (32'(r_ptr) + k) % M;
      if (!w_rr_vld && in_valid[SW'(idx)]) begin
        w_rr_vld   = 1'b1;
        w_rr_grant = SW'(idx);
      end
    end
  end

  assign w_grant     = mode ? w_rr_grant : S;
  assign w_grant_vld = mode ? w_rr_vld : w_fix_vld;

  always_comb begin
    w_grant_data = '0;
    for (int unsigned i = 0; i < M; i++) begin
      if (w_grant == SW'(i)) w_grant_data = in_data[i*N +: N];
    end
  end

  // Ready is held low while reset is asserted so no beat is consumed during the reset cycle.
  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < M; i++) begin
      in_ready[SW'(i)] = w_grant_vld && (w_grant == SW'(i)) && w_load_en && !rst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y       <= '0;
      r_y_ch    <= '0;
      r_y_valid <= 1'b0;
      r_ptr     <= SW'(M - 1);
    end else if (w_load_en) begin
      if (w_grant_vld) begin
        r_y       <= w_grant_data;
        r_y_ch    <= w_grant;
        r_y_valid <= 1'b1;
        if (mode) r_ptr <= w_grant;
      end else begin
        r_y_valid <= 1'b0;
      end
    end
  end

  assign Y       = r_y;
  assign Y_ch    = r_y_ch;
  assign Y_valid = r_y_valid;

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));

endmodule

// File: tb/tb_stream_mux.sv
// Directed bench for stream_mux: expected beats are queued by the stimulus thread and
// consumed by a monitor thread on every output transfer; an M=3 instance covers the out-of-range select.
module tb_stream_mux;
  localparam int unsigned N  = 32;
  localparam int unsigned M  = 4;
  localparam int unsigned SW = 2;
  localparam int unsigned M3 = 3;
  localparam int unsigned SW3 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, mode, Y_ready, Y_valid;
  logic [SW-1:0]  S, Y_ch;
  logic [M*N-1:0] in_data;
  logic [M-1:0]   in_valid, in_ready;
  logic [N-1:0]   Y;

  logic            mode3, Y_ready3, Y_valid3;
  logic [SW3-1:0]  S3, Y_ch3;
  logic [M3*N-1:0] in_data3;
  logic [M3-1:0]   in_valid3, in_ready3;
  logic [N-1:0]    Y3;

  stream_mux #(.N(N), .M(M)) u_dut4 (
    .clk(clk), .rst(rst), .mode(mode), .S(S), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .Y(Y), .Y_valid(Y_valid), .Y_ch(Y_ch), .Y_ready(Y_ready)
  );

  stream_mux #(.N(N), .M(M3)) u_dut3 (
    .clk(clk), .rst(rst), .mode(mode3), .S(S3), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .Y(Y3), .Y_valid(Y_valid3), .Y_ch(Y_ch3), .Y_ready(Y_ready3)
  );

  typedef struct packed {
    logic [N-1:0]  data;
    logic [SW-1:0] ch;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    checks;
  int    errors;

  function automatic logic [N-1:0] dat4(int unsigned ch);
    return 32'hCAFE0000 + N'(ch);
  endfunction

  function automatic logic [N-1:0] dat3(int unsigned ch);
    return 32'hBEEF0000 + N'(ch);
  endfunction

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int unsigned ch);
    beat_t b;
    b.data = dat4(ch);
    b.ch   = SW'(ch);
    exp_q.push_back(b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; mode = 1'b1; S = '0; Y_ready = 1'b1; in_valid = '1;
    for (int i = 0; i < int'(M); i++) in_data[i*N +: N] = dat4(i);
    mode3 = 1'b0; S3 = '0; Y_ready3 = 1'b1; in_valid3 = '0;
    for (int i = 0; i < int'(M3); i++) in_data3[i*N +: N] = dat3(i);

    // Monitor: every output transfer must match the head of the expected queue.
    fork
      forever begin
        @(negedge clk);
        if (rst === 1'b0 && Y_valid === 1'b1 && Y_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_extra: got beat ch %0d data %h, expected no beat", Y_ch, Y);
          end else begin
            mon_e = exp_q.pop_front();
            chk("sb_data", Y, mon_e.data);
            chk("sb_ch", N'(Y_ch), N'(mon_e.ch));
          end
        end
      end
    join_none

    // Reset held two cycles with every channel valid.
    tick(); tick();
    chk("rst_y_valid", N'(Y_valid), 32'd0);
    chk("rst_y", Y, 32'd0);
    chk("rst_y_ch", N'(Y_ch), 32'd0);
    chk("rst_in_ready", N'(in_ready), 32'd0);
    chk("rst_y_valid3", N'(Y_valid3), 32'd0);

    // Round-robin fairness, all valid.
    for (int i = 0; i < 8; i++) push(i % 4);
    rst = 1'b0;
    #1 chk("rr_first_ready", N'(in_ready), 32'h1);
    repeat (8) tick();
    in_valid = '0;
    tick();
    chk("rr_drained", N'(Y_valid), 32'd0);

    // Round-robin with channels 1 and 3 only.
    push(1); push(3); push(1); push(3);
    in_valid = 4'b1010;
    #1 chk("rr1010_ready", N'(in_ready), 32'h2);
    repeat (4) tick();
    in_valid = '0;
    tick();

    // Fixed select.
    mode = 1'b0; S = 2'd2; in_valid = 4'b1111;
    #1 chk("fix_ready", N'(in_ready), 32'h4);
    push(2);
    tick();
    chk("fix_y", Y, 32'hCAFE0002);
    chk("fix_y_ch", N'(Y_ch), 32'd2);
    chk("fix_y_valid", N'(Y_valid), 32'd1);
    S = 2'd3; in_valid = 4'b0111;
    #1 chk("fix_s3_ready", N'(in_ready), 32'd0);
    tick();
    chk("fix_s3_y_valid", N'(Y_valid), 32'd0);
    chk("fix_s3_y_hold", Y, 32'hCAFE0002);

    // Backpressure; fixed-mode traffic must not have moved the round-robin pointer.
    mode = 1'b1; in_valid = 4'b1111; Y_ready = 1'b0;
    #1 chk("bp_ready_empty", N'(in_ready), 32'h1);
    push(0);
    tick();
    for (int j = 0; j < 3; j++) begin
      chk("bp_y", Y, 32'hCAFE0000);
      chk("bp_y_ch", N'(Y_ch), 32'd0);
      chk("bp_y_valid", N'(Y_valid), 32'd1);
      chk("bp_ready", N'(in_ready), 32'd0);
      tick();
    end
    Y_ready = 1'b1;
    #1 chk("bp_release_ready", N'(in_ready), 32'h2);
    tick();
    chk("bp_nobubble_ch", N'(Y_ch), 32'd1);
    chk("bp_nobubble_valid", N'(Y_valid), 32'd1);
    Y_ready = 1'b0;

    // Reset with a held beat: the beat is dropped and the pointer restarts.
    rst = 1'b1;
    tick();
    chk("mid_rst_y_valid", N'(Y_valid), 32'd0);
    chk("mid_rst_y", Y, 32'd0);
    chk("mid_rst_y_ch", N'(Y_ch), 32'd0);
    rst = 1'b0; Y_ready = 1'b1;
    #1 chk("mid_rst_ready", N'(in_ready), 32'h1);
    push(0);
    tick();
    chk("mid_rst_grant", N'(Y_ch), 32'd0);
    in_valid = '0;
    tick();

    // M=3: select 3 does not exist.
    in_valid3 = 3'b111; S3 = 2'd0; Y_ready3 = 1'b0;
    tick();
    chk("m3_load_valid", N'(Y_valid3), 32'd1);
    chk("m3_load_y", Y3, 32'hBEEF0000);
    S3 = 2'd3; Y_ready3 = 1'b1;
    #1 chk("m3_s3_ready", N'(in_ready3), 32'd0);
    tick();
    chk("m3_s3_y_valid", N'(Y_valid3), 32'd0);
    chk("m3_s3_y_hold", Y3, 32'hBEEF0000);
    chk("m3_s3_ready_idle", N'(in_ready3), 32'd0);

    tick();
    chk("sb_empty", N'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
